// File: rtl/ann_wb_bridge.sv
// ann_wb_bridge: Wishbone-classic slave front end for the ANN accelerator.
// Decodes a small register window. Buffers query words into an input FIFO
// that streams to the core, and result words from the core into an output
// FIFO that firmware drains. Also handles start/busy/done/IRQ.
// Ports:
//   wb_clk_i, wb_rst_ni                   clock, async active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i          Wishbone request
//   wbs_ack_o, wbs_dat_o                  single-cycle ack, registered read data
//   in_valid_o/in_data_o/in_ready_i       query stream to the core
//   out_valid_i/out_data_i/out_ready_o    result stream from the core
//   start_o, done_i, irq_o                control pulse, completion, level IRQ
module ann_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              in_valid_o,
  output logic [DATA_W-1:0] in_data_o,
  input  logic              in_ready_i,
  input  logic              out_valid_i,
  input  logic [DATA_W-1:0] out_data_i,
  output logic              out_ready_o,
  output logic              start_o,
  input  logic              done_i,
  output logic              irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_IN     = 6'h02;
  localparam logic [5:0] OFF_OUT    = 6'h03;
  localparam logic [5:0] OFF_CLR    = 6'h04;

  logic [DATA_W-1:0] in_mem_q  [DEPTH];
  logic [DATA_W-1:0] out_mem_q [DEPTH];

  logic [PW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [PW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          start_q, start_d;
  logic          irq_en_q, irq_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_ovf_q, in_ovf_d;
  logic          out_udf_q, out_udf_d;
  logic          irq_q, irq_d;

  logic          req_c, hit_c, wr_c, rd_c;
  logic [5:0]    off_c;
  logic [PW-1:0] in_cnt_c, out_cnt_c;
  logic          in_full_c, in_empty_c, out_full_c, out_empty_c;
  logic          ctrl_wr_c, clr_wr_c, flush_c;
  logic          in_push_c, in_pop_c, out_push_c, out_pop_c;
  logic [31:0]   status_c, rdata_c;
  logic          unused_c;

  // Request decode; off-window requests are still acked but do nothing.
  assign req_c = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign hit_c = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off_c = wbs_adr_i[7:2];
  assign wr_c  = req_c & hit_c & wbs_we_i;
  assign rd_c  = req_c & hit_c & ~wbs_we_i;
  assign unused_c = ^{wbs_adr_i[1:0], wbs_sel_i[3:1]};

  // FIFO occupancy, all taken before this cycle's operations.
  assign in_cnt_c    = in_wptr_q - in_rptr_q;
  assign out_cnt_c   = out_wptr_q - out_rptr_q;
  assign in_full_c   = (in_cnt_c == PW'(DEPTH));
  assign in_empty_c  = (in_cnt_c == '0);
  assign out_full_c  = (out_cnt_c == PW'(DEPTH));
  assign out_empty_c = (out_cnt_c == '0);

  assign ctrl_wr_c  = wr_c & (off_c == OFF_CTRL) & wbs_sel_i[0];
  assign clr_wr_c   = wr_c & (off_c == OFF_CLR);
  assign flush_c    = ctrl_wr_c & wbs_dat_i[2];
  assign in_push_c  = wr_c & (off_c == OFF_IN) & ~in_full_c;
  assign in_pop_c   = ~in_empty_c & in_ready_i;
  assign out_push_c = out_valid_i & ~out_full_c;
  assign out_pop_c  = rd_c & (off_c == OFF_OUT) & ~out_empty_c;

  assign status_c = {8'h00, 8'(out_cnt_c), 8'(in_cnt_c),
                     out_udf_q, in_ovf_q, done_q, busy_q,
                     out_empty_c, out_full_c, in_empty_c, in_full_c};

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_CTRL:   rdata_c = {30'd0, irq_en_q, 1'b0};
      OFF_STATUS: rdata_c = status_c;
      OFF_OUT:    if (!out_empty_c) rdata_c = 32'(out_mem_q[out_rptr_q[AW-1:0]]);
      default:    rdata_c = '0;
    endcase
  end

  // Next-state for control, flags and pointers
  always_comb begin
    ack_d      = req_c;
    dat_d      = '0;
    start_d    = ctrl_wr_c & wbs_dat_i[0];
    irq_en_d   = irq_en_q;
    busy_d     = busy_q;
    done_d     = done_q;
    in_ovf_d   = in_ovf_q;
    out_udf_d  = out_udf_q;
    in_wptr_d  = in_wptr_q + PW'(in_push_c);
    in_rptr_d  = in_rptr_q + PW'(in_pop_c);
    out_wptr_d = out_wptr_q + PW'(out_push_c);
    out_rptr_d = out_rptr_q + PW'(out_pop_c);

    if (rd_c) dat_d = rdata_c;
    if (ctrl_wr_c) irq_en_d = wbs_dat_i[1];
    // START beats a coincident done_i for busy.
    if (done_i) busy_d = 1'b0;
    if (start_d) busy_d = 1'b1;
    // Sticky flags: set wins over a same-cycle clear.
    if (clr_wr_c && wbs_dat_i[0]) done_d = 1'b0;
    if (done_i) done_d = 1'b1;
    if (clr_wr_c && wbs_dat_i[1]) in_ovf_d = 1'b0;
    if (wr_c && (off_c == OFF_IN) && in_full_c) in_ovf_d = 1'b1;
    if (clr_wr_c && wbs_dat_i[2]) out_udf_d = 1'b0;
    if (rd_c && (off_c == OFF_OUT) && out_empty_c) out_udf_d = 1'b1;
    if (flush_c) begin
      in_wptr_d  = '0;
      in_rptr_d  = '0;
      out_wptr_d = '0;
      out_rptr_d = '0;
    end
    irq_d = done_d & irq_en_d;
  end

  // State registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      start_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ovf_q   <= 1'b0;
      out_udf_q  <= 1'b0;
      irq_q      <= 1'b0;
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      start_q    <= start_d;
      irq_en_q   <= irq_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ovf_q   <= in_ovf_d;
      out_udf_q  <= out_udf_d;
      irq_q      <= irq_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
    end
  end

  // FIFO storage; a write racing a flush lands in a slot that is then discarded.
  always_ff @(posedge wb_clk_i) begin
    if (in_push_c)  in_mem_q[in_wptr_q[AW-1:0]]   <= DATA_W'(wbs_dat_i);
    if (out_push_c) out_mem_q[out_wptr_q[AW-1:0]] <= out_data_i;
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign start_o     = start_q;
  assign irq_o       = irq_q;
  assign in_valid_o  = ~in_empty_c;
  assign in_data_o   = in_mem_q[in_rptr_q[AW-1:0]];
  assign out_ready_o = ~out_full_c;

endmodule

// File: doc/ann_wb_bridge.md
# ann_wb_bridge

Wishbone-classic slave that sits inside the Caravel user project, directly downstream of the wrapper's `wbs_*` bus. It is the management-SoC-facing front end of the ANN accelerator. It decodes a small register window and buffers query words into an input FIFO that streams to the accelerator core. It buffers result words from the core into an output FIFO that firmware drains. It also provides start, status, done and IRQ handling.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: register window base; decode compares `wbs_adr_i[31:8]` against `BASE_ADDR[31:8]`.
- `DEPTH`, default 8: entries per FIFO; must be a power of 2, range 2..128.
- `DATA_W`, default 32: stream width; fixed at 32 in this revision.

Ports:
- `wb_clk_i`, in, 1: sole clock. All logic runs on the rising edge.
- `wb_rst_ni`, in, 1: reset. Asynchronous assert, active-low. The parent inverts `wb_rst_i` to produce it.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`, in, 1 each: Wishbone classic control signals.
- `wbs_sel_i`, in, 4: byte selects. Only CTRL honours them, via `sel[0]`.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_dat_i`, in, 32: write data.
- `wbs_ack_o`, out, 1: single-cycle acknowledge.
- `wbs_dat_o`, out, 32: read data, valid while `wbs_ack_o` is high.
- `in_valid_o`, out, 1; `in_data_o`, out, 32; `in_ready_i`, in, 1: query stream to the core.
- `out_valid_i`, in, 1; `out_data_i`, in, 32; `out_ready_o`, out, 1: result stream from the core.
- `start_o`, out, 1: one-cycle start pulse to the core.
- `done_i`, in, 1: one-cycle completion pulse from the core.
- `irq_o`, out, 1: level interrupt, connected to `user_irq[0]`.

## Operation
A request is accepted in any cycle where `cyc & stb & !wbs_ack_o` holds. Accepted requests are acknowledged whether or not the address decodes. Off-window and unmapped offsets read 0 and ignore writes.

The register map is decoded from `adr[7:2]`:
- 0x00 CTRL (RW):
  - bit0 START: write-1 produces a `start_o` pulse; reads 0.
  - bit1 IRQ_EN: stored.
  - bit2 FLUSH: write-1 empties both FIFOs; reads 0.
  - A CTRL write takes effect only when `sel[0]=1`.
- 0x04 STATUS (RO):
  - bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty.
  - bit4 busy, bit5 done, bit6 in_ovf, bit7 out_udf.
  - [15:8] in_count, [23:16] out_count, both zero-extended.
- 0x08 IN_DATA (WO): pushes `wbs_dat_i` into the input FIFO. If the FIFO is full, the word is dropped and in_ovf is set (sticky).
- 0x0C OUT_DATA (RO): pops the output FIFO head onto `wbs_dat_o`. If the FIFO is empty, the read returns 0, sets out_udf (sticky) and changes no pointers.
- 0x10 CLR (WO): write-1 to bit0 clears done; bit1 clears in_ovf; bit2 clears out_udf.

Core-side streams:
- `in_valid_o = !in_empty`. `in_data_o` is the input FIFO head. A pop occurs on `in_valid_o & in_ready_i`.
- `out_ready_o = !out_full`. A push occurs on `out_valid_i & out_ready_o`.
- Each FIFO has a circular buffer, read/write pointers with a wrap bit, and count = wptr - rptr.

Busy, done and IRQ:
- busy is set by START and cleared by `done_i`.
- done is set by `done_i` and cleared by CLR bit0. If both occur in the same cycle, set wins.
- `irq_o = done & IRQ_EN`.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `start_o`=0, `irq_o`=0, `in_valid_o`=0, `out_ready_o`=1. All pointers, counts, IRQ_EN, busy, done, in_ovf and out_udf are 0.
- Reset asserted mid-transfer: everything returns to reset values immediately. The FIFOs are emptied. A pending request is not acked.
- A request sampled at edge k gives `wbs_ack_o`=1 during cycle k+1 and 0 at edge k+2. Back-to-back requests therefore complete at most every second cycle.
- The FIFO push (IN_DATA write) and the FIFO pop (OUT_DATA read) happen at edge k. Read data is registered at edge k.
- `start_o` is high exactly during cycle k+1 after a START write sampled at edge k.
- Full/empty are evaluated before same-cycle operations:
  - A WB push to a full input FIFO is dropped even if the core pops in the same cycle.
  - A WB pop from an empty output FIFO underflows even if the core pushes in the same cycle.
  - Push and pop on a non-full, non-empty FIFO in the same cycle leave count unchanged.
- FLUSH overrides any same-cycle push or pop on both FIFOs.
- Pointers wrap modulo DEPTH. A full FIFO has count=DEPTH and equal indices with differing wrap bits.
- Latency from an IN_DATA write at edge k to `in_valid_o`=1 is cycle k+1.

## Test plan
- Reset → STATUS read returns 0x0000_000A. `out_ready_o`=1, `irq_o`=0, `wbs_ack_o`=0.
- Write 0x11,0x22,…,0x88 to IN_DATA with `in_ready_i`=0, then a ninth write of 0x99 → STATUS in_full=1, in_ovf=1, in_count=8. Then raise `in_ready_i` → core receives 0x11..0x88 in order; 0x99 never appears.
- Core pushes 0xA5A5_0001..0xA5A5_0003; firmware issues four OUT_DATA reads → first three reads return the words in order, the fourth returns 0 with out_udf=1.
- Set CTRL to 0x3 → one-cycle `start_o`, busy=1. Pulse `done_i` → busy=0, done=1, `irq_o`=1. Write CLR 0x1 in the same cycle as another `done_i` → done stays 1.
- Issue reads and writes to offset 0x20 and to address BASE_ADDR+0x100 → each is acked once, reads return 0, no state changes.
- Hold 3 words in each FIFO, then write CTRL FLUSH concurrently with a core push → both FIFOs are empty and counts are 0. Assert `wb_rst_ni` low mid-request → no ack is issued and all outputs return to reset values.
